// File: rtl/odd_issue_ctrl_pkg.sv
`default_nettype none
// odd_issue_ctrl_pkg: shared constants and types for the odd-pipe issue controller.
// Revision: 1.0
package odd_issue_ctrl_pkg;
  localparam logic [2:0] UNIT_PERM = 3'b100;
  localparam logic [2:0] UNIT_LS   = 3'b101;
  localparam logic [2:0] UNIT_BR   = 3'b110;
  localparam logic [2:0] FWD_RF    = 3'd0;

  localparam int REG_W = 7;
  localparam int LAT_W = 4;
  localparam int SEL_W = 3;

  // Bit offsets of one flattened shadow entry; must track shadow_t below.
  localparam int ENT_LAT_LSB   = 0;
  localparam int ENT_WR_BIT    = 4;
  localparam int ENT_DST_LSB   = 5;
  localparam int ENT_VALID_BIT = 12;
  localparam int ENT_W         = 13;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] dst;
    logic             wr;
    logic [LAT_W-1:0] lat;
  } shadow_t;

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_BR_PEND = 1'b1
  } br_state_t;
endpackage
`default_nettype wire

// File: rtl/odd_issue_ctrl_fwd_lookup.sv
`default_nettype none
// odd_fwd_lookup: finds the youngest in-flight writer of one operand and flags a RAW hazard.
// Revision: 1.0
module odd_fwd_lookup
  import odd_issue_ctrl_pkg::*;
#(
  parameter int DEPTH = 7
) (
  input  logic [DEPTH*ENT_W-1:0] i_entries,
  input  logic [0:6]             i_addr,
  input  logic                   i_used,
  output logic                   o_hazard,
  output logic [0:2]             o_sel
);

  // Scanning oldest-to-youngest lets the youngest match overwrite older ones.
  always_comb begin
    o_hazard = 1'b0;
    o_sel    = FWD_RF;
    if (i_used) begin
      for (int s = DEPTH; s >= 1; s--) begin
        if (i_entries[(s-1)*ENT_W + ENT_VALID_BIT] &&
            i_entries[(s-1)*ENT_W + ENT_WR_BIT] &&
            (i_entries[(s-1)*ENT_W + ENT_DST_LSB +: REG_W] == i_addr)) begin
          o_sel    = SEL_W'(s);
          o_hazard = (s < int'(i_entries[(s-1)*ENT_W + ENT_LAT_LSB +: LAT_W])) && (s < DEPTH);
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/odd_issue_ctrl.sv
`default_nettype none
// odd_issue_ctrl: odd-pipe issue gate with RAW scoreboard, forwarding selects and branch hold.
// Revision: 1.0
module odd_issue_ctrl
  import odd_issue_ctrl_pkg::*;
#(
  parameter int DEPTH  = 7,
  parameter int BR_LAT = 2,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             dec_valid,
  input  logic [0:2]       dec_unit_id,
  input  logic [0:6]       dec_reg_dst,
  input  logic             dec_reg_wr,
  input  logic [0:3]       dec_latency,
  input  logic [0:6]       dec_ra_addr,
  input  logic [0:6]       dec_rb_addr,
  input  logic [0:6]       dec_rc_addr,
  input  logic [0:2]       dec_src_used,
  output logic             dec_ready,
  output logic             issue_valid,
  output logic [0:2]       fwd_sel_ra,
  output logic [0:2]       fwd_sel_rb,
  output logic [0:2]       fwd_sel_rc,
  output logic             stall_raw,
  output logic             stall_br,
  output logic [0:CNT_W-1] stall_cnt
);

  localparam int BR_W = (BR_LAT < 2) ? 1 : $clog2(BR_LAT + 1);

  shadow_t                r_shadow [1:DEPTH];
  br_state_t              r_state;
  logic [BR_W-1:0]        r_br_cnt;
  shadow_t                w_new;
  logic [DEPTH*ENT_W-1:0] w_flat;
  logic [REG_W-1:0]       w_addr [3];
  logic [SEL_W-1:0]       w_sel  [3];
  logic [2:0]             w_haz;

  for (genvar s = 1; s <= DEPTH; s++) begin : g_flat
    assign w_flat[(s-1)*ENT_W +: ENT_W] = r_shadow[s];
  end

  assign w_addr[0] = dec_ra_addr;
  assign w_addr[1] = dec_rb_addr;
  assign w_addr[2] = dec_rc_addr;

  for (genvar k = 0; k < 3; k++) begin : g_lookup
    odd_fwd_lookup #(.DEPTH(DEPTH)) u_lookup (
      .i_entries (w_flat),
      .i_addr    (w_addr[k]),
      .i_used    (dec_src_used[k]),
      .o_hazard  (w_haz[k]),
      .o_sel     (w_sel[k])
    );
  end

  assign fwd_sel_ra = w_sel[0];
  assign fwd_sel_rb = w_sel[1];
  assign fwd_sel_rc = w_sel[2];

  assign stall_raw = dec_valid & (|w_haz);
  assign stall_br  = dec_valid & (r_state == ST_BR_PEND);
  assign dec_ready = dec_valid & ~stall_raw & ~stall_br;

  // A zero latency field means forwardable from stage 1.
  always_comb begin
    w_new = '0;
    if (dec_ready) begin
      w_new.valid = 1'b1;
      w_new.dst   = dec_reg_dst;
      w_new.wr    = dec_reg_wr;
      w_new.lat   = (dec_latency == '0) ? LAT_W'(1) : dec_latency;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int s = 1; s <= DEPTH; s++) r_shadow[s] <= '0;
      r_state     <= ST_IDLE;
      r_br_cnt    <= '0;
      issue_valid <= 1'b0;
      stall_cnt   <= '0;
    end else begin
      r_shadow[1] <= w_new;
      for (int s = 2; s <= DEPTH; s++) r_shadow[s] <= r_shadow[s-1];
      issue_valid <= dec_ready;
      if ((stall_raw || stall_br) && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (dec_ready && (dec_unit_id == UNIT_BR)) begin
            r_state  <= ST_BR_PEND;
            r_br_cnt <= BR_W'(BR_LAT);
          end
        end
        ST_BR_PEND: begin
          if (r_br_cnt <= BR_W'(1)) begin
            r_state  <= ST_IDLE;
            r_br_cnt <= '0;
          end else begin
            r_br_cnt <= r_br_cnt - 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_odd_issue_ctrl.sv
`default_nettype none
// tb_odd_issue_ctrl: scoreboard bench for the odd-pipe issue controller.
// Revision: 1.0
module tb_odd_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        dec_valid = 1'b0;
  logic [0:2]  dec_unit_id = '0;
  logic [0:6]  dec_reg_dst = '0;
  logic        dec_reg_wr = 1'b0;
  logic [0:3]  dec_latency = '0;
  logic [0:6]  dec_ra_addr = '0;
  logic [0:6]  dec_rb_addr = '0;
  logic [0:6]  dec_rc_addr = '0;
  logic [0:2]  dec_src_used = '0;
  logic        dec_ready;
  logic        issue_valid;
  logic [0:2]  fwd_sel_ra;
  logic [0:2]  fwd_sel_rb;
  logic [0:2]  fwd_sel_rc;
  logic        stall_raw;
  logic        stall_br;
  logic [0:15] stall_cnt;

  odd_issue_ctrl #(.DEPTH(7), .BR_LAT(2), .CNT_W(16)) u_dut (
    .clk          (clk),
    .rst          (rst),
    .dec_valid    (dec_valid),
    .dec_unit_id  (dec_unit_id),
    .dec_reg_dst  (dec_reg_dst),
    .dec_reg_wr   (dec_reg_wr),
    .dec_latency  (dec_latency),
    .dec_ra_addr  (dec_ra_addr),
    .dec_rb_addr  (dec_rb_addr),
    .dec_rc_addr  (dec_rc_addr),
    .dec_src_used (dec_src_used),
    .dec_ready    (dec_ready),
    .issue_valid  (issue_valid),
    .fwd_sel_ra   (fwd_sel_ra),
    .fwd_sel_rb   (fwd_sel_rb),
    .fwd_sel_rc   (fwd_sel_rc),
    .stall_raw    (stall_raw),
    .stall_br     (stall_br),
    .stall_cnt    (stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] ra;
    logic [2:0] rb;
    logic [2:0] rc;
    logic [7:0] raw_st;
    logic [7:0] br_st;
  } exp_t;

  exp_t q_exp[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   exp_cnt = 0;

  localparam logic [2:0] U_PERM = 3'b100;
  localparam logic [2:0] U_LS   = 3'b101;
  localparam logic [2:0] U_BR   = 3'b110;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Called just after a falling edge; returns just after a later falling edge.
  task automatic send(input string tag, input logic [2:0] unit, input logic [6:0] dst,
                      input logic wr, input logic [3:0] lat, input logic [6:0] ra,
                      input logic [6:0] rb, input logic [6:0] rc, input logic [2:0] used,
                      input logic [2:0] e_ra, input logic [2:0] e_rb, input logic [2:0] e_rc,
                      input int e_raw, input int e_br);
    exp_t e;
    exp_t g;
    int   raw_n = 0;
    int   br_n  = 0;
    bit   accepted = 0;
    logic [2:0] o_ra = '0, o_rb = '0, o_rc = '0;
    e = '{ra: e_ra, rb: e_rb, rc: e_rc, raw_st: 8'(e_raw), br_st: 8'(e_br)};
    q_exp.push_back(e);
    dec_valid = 1'b1; dec_unit_id = unit; dec_reg_dst = dst; dec_reg_wr = wr;
    dec_latency = lat; dec_ra_addr = ra; dec_rb_addr = rb; dec_rc_addr = rc;
    dec_src_used = used;
    for (int i = 0; i < 30 && !accepted; i++) begin
      #1;
      if (dec_ready) begin
        accepted = 1;
        o_ra = fwd_sel_ra; o_rb = fwd_sel_rb; o_rc = fwd_sel_rc;
      end else begin
        if (stall_raw) raw_n++;
        if (stall_br)  br_n++;
        @(negedge clk);
      end
    end
    if (!accepted) chk({tag, "_timeout"}, 0, 1);
    @(posedge clk);
    #1 dec_valid = 1'b0;
    @(negedge clk);
    #1;
    chk({tag, "_issue_valid"}, 32'(issue_valid), 32'(accepted));
    g = q_exp.pop_front();
    chk({tag, "_sel_ra"}, 32'(o_ra), 32'(g.ra));
    chk({tag, "_sel_rb"}, 32'(o_rb), 32'(g.rb));
    chk({tag, "_sel_rc"}, 32'(o_rc), 32'(g.rc));
    chk({tag, "_raw_stalls"}, 32'(raw_n), 32'(g.raw_st));
    chk({tag, "_br_stalls"}, 32'(br_n), 32'(g.br_st));
    exp_cnt += int'(g.raw_st) + int'(g.br_st);
    chk({tag, "_stall_cnt"}, 32'(stall_cnt), 32'(exp_cnt));
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_issue_valid"}, 32'(issue_valid), 0);
    chk({tag, "_dec_ready"}, 32'(dec_ready), 0);
    chk({tag, "_fwd_sels"}, {23'd0, fwd_sel_ra, fwd_sel_rb, fwd_sel_rc}, 0);
    chk({tag, "_stalls"}, {30'd0, stall_raw, stall_br}, 0);
    chk({tag, "_stall_cnt"}, 32'(stall_cnt), 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #1 check_idle("in_reset");
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1 check_idle("post_reset");

    // RAW on a latency-4 permute result
    send("prod5", U_PERM, 7'd5, 1'b1, 4'd4, 7'd0, 7'd0, 7'd0, 3'b000, 0, 0, 0, 0, 0);
    send("use5",  U_PERM, 7'd50, 1'b0, 4'd1, 7'd5, 7'd0, 7'd0, 3'b100, 4, 0, 0, 3, 0);

    // Two loads to r9: the younger one governs
    send("ld9a",  U_LS, 7'd9, 1'b1, 4'd6, 7'd0, 7'd0, 7'd0, 3'b000, 0, 0, 0, 0, 0);
    send("fill",  U_LS, 7'd60, 1'b0, 4'd1, 7'd0, 7'd0, 7'd0, 3'b000, 0, 0, 0, 0, 0);
    send("ld9b",  U_LS, 7'd9, 1'b1, 4'd6, 7'd0, 7'd0, 7'd0, 3'b000, 0, 0, 0, 0, 0);
    send("use9",  U_PERM, 7'd61, 1'b0, 4'd1, 7'd0, 7'd9, 7'd0, 3'b010, 0, 6, 0, 5, 0);

    // Producer drains out of the shadow
    send("prod12", U_PERM, 7'd12, 1'b1, 4'd2, 7'd0, 7'd0, 7'd0, 3'b000, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++)
      send("nodep", U_PERM, 7'd70, 1'b1, 4'd1, 7'd1, 7'd2, 7'd3, 3'b111, 0, 0, 0, 0, 0);
    send("use12", U_PERM, 7'd71, 1'b0, 4'd1, 7'd0, 7'd0, 7'd12, 3'b001, 0, 0, 0, 0, 0);

    // Zero latency behaves as 1; latency DEPTH forwards from the last stage
    send("prod20", U_PERM, 7'd20, 1'b1, 4'd0, 7'd0, 7'd0, 7'd0, 3'b000, 0, 0, 0, 0, 0);
    send("use20",  U_PERM, 7'd72, 1'b0, 4'd1, 7'd20, 7'd0, 7'd0, 3'b100, 1, 0, 0, 0, 0);
    send("prod30", U_LS, 7'd30, 1'b1, 4'd7, 7'd0, 7'd0, 7'd0, 3'b000, 0, 0, 0, 0, 0);
    send("use30",  U_PERM, 7'd73, 1'b0, 4'd1, 7'd0, 7'd30, 7'd0, 3'b010, 0, 7, 0, 6, 0);

    // Store (no write) is never matched; unused operand ignored
    send("st33",  U_LS, 7'd33, 1'b0, 4'd5, 7'd0, 7'd0, 7'd0, 3'b000, 0, 0, 0, 0, 0);
    send("use33", U_PERM, 7'd74, 1'b0, 4'd1, 7'd33, 7'd33, 7'd33, 3'b111, 0, 0, 0, 0, 0);

    // Branch hold
    send("br",    U_BR, 7'd0, 1'b0, 4'd1, 7'd0, 7'd0, 7'd0, 3'b000, 0, 0, 0, 0, 0);
    send("postbr", U_PERM, 7'd75, 1'b0, 4'd1, 7'd0, 7'd0, 7'd0, 3'b000, 0, 0, 0, 0, 2);

    // Reset while a branch is pending with three live entries
    send("p40",   U_PERM, 7'd40, 1'b1, 4'd4, 7'd0, 7'd0, 7'd0, 3'b000, 0, 0, 0, 0, 0);
    send("p41",   U_PERM, 7'd41, 1'b1, 4'd4, 7'd0, 7'd0, 7'd0, 3'b000, 0, 0, 0, 0, 0);
    send("br2",   U_BR, 7'd0, 1'b0, 4'd1, 7'd0, 7'd0, 7'd0, 3'b000, 0, 0, 0, 0, 0);
    rst = 1'b0;
    #1 check_idle("mid_reset");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    exp_cnt = 0;
    #1;
    send("use40", U_PERM, 7'd76, 1'b0, 4'd1, 7'd40, 7'd0, 7'd0, 3'b100, 0, 0, 0, 0, 0);

    chk("queue_empty", 32'(q_exp.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/odd_issue_ctrl.md
Name: odd_issue_ctrl

Overview:
- Issue controller and scoreboard in front of the odd pipe (permute / load-store / branch).
- Accepts one decoded instruction per cycle and checks RAW hazards against a 7-entry in-flight shadow of the odd-pipe stages.
- Drives per-operand forwarding selects.
- Holds issue behind an unresolved branch.

Parameters:
- DEPTH, 7, number of odd-pipe stages tracked (packed stages 1..DEPTH).
- BR_LAT, 2, cycles after branch issue before the branch is considered resolved.
- CNT_W, 16, width of the saturating stall counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset asserted).
- dec_valid  in  1  decoded odd instruction present.
- dec_unit_id  in  [0:2]  unit id: 100 = permute, 101 = load/store, 110 = branch.
- dec_reg_dst  in  [0:6]  destination register.
- dec_reg_wr  in  1  instruction writes dec_reg_dst.
- dec_latency  in  [0:3]  stage at which the result becomes forwardable (1..DEPTH).
- dec_ra_addr, dec_rb_addr, dec_rc_addr  in  [0:6] each  source registers.
- dec_src_used  in  [0:2]  operand-used bits, order ra, rb, rc.
- dec_ready  out  1  instruction accepted this cycle.
- issue_valid  out  1  registered; the instruction enters odd-pipe stage 1 this cycle.
- fwd_sel_ra, fwd_sel_rb, fwd_sel_rc  out  [0:2] each  0 = register file, s = packed stage s.
- stall_raw  out  1  stall caused by a RAW hazard.
- stall_br  out  1  stall caused by a pending branch.
- stall_cnt  out  [0:CNT_W-1]  count of stalled cycles.

Behaviour:
- Reset (rst = 0, async):
  - All shadow entries invalid, state IDLE, branch counter 0.
  - issue_valid = 0, stall_cnt = 0.
  - Combinational outputs then evaluate to 0 (dec_ready = 0 whenever dec_valid = 0).
- Shadow pipeline:
  - Entries 1..DEPTH each hold {valid, reg_dst, reg_wr, latency}.
  - Every cycle, entry s+1 <= entry s.
  - Entry 1 <= the accepted instruction, or invalid if nothing was accepted.
  - Entry DEPTH is discarded after its WB cycle.
  - The register file has write-bypass, so the WB stage never causes a hazard.
- Operand lookup, per used operand, combinational:
  - Find the lowest-numbered valid entry s with reg_wr = 1 and reg_dst = operand address.
  - No match: fwd_sel = 0.
  - Match with s >= latency: fwd_sel = s.
  - Match with s < latency: hazard. Older entries are never consulted past the youngest match.
- Unused operands: no hazard, fwd_sel = 0.
- stall_raw = dec_valid AND (any hazard on a used operand).
- Branch FSM, states IDLE and BR_PEND:
  - IDLE -> BR_PEND when a branch (unit 110) is accepted; the counter loads BR_LAT.
  - In BR_PEND the counter decrements each cycle; the state returns to IDLE on the cycle after the counter reaches 1.
  - stall_br = dec_valid AND (state == BR_PEND).
- dec_ready = dec_valid AND NOT stall_raw AND NOT stall_br.
- issue_valid <= dec_ready (1-cycle latency); fwd_sel values are combinational for the accepted cycle.
- stall_cnt increments by 1 on each cycle with stall_raw OR stall_br, and saturates at all-ones.
- Simultaneous events: a branch hazard and a RAW hazard may both assert; stall_cnt still increments by 1.
- An instruction with reg_wr = 0 (e.g. a store) is tracked but never matched.
- A latency field of 0 is treated as 1.
- Reset mid-operation drops all in-flight tracking and any pending branch immediately.

Decomposition:
- Shared package (alongside the existing opcode include): unit-id constants UNIT_PERM = 100, UNIT_LS = 101, UNIT_BR = 110; the FWD_RF = 0 select value; shadow-entry field offsets.
- One natural sub-module: odd_fwd_lookup, combinational, one instance per operand; takes the entries and an address, returns {hazard, sel}.

Test Plan:
- Reset release with no input -> issue_valid = 0, all fwd_sel = 0, stall_cnt = 0.
- Issue permute dst = 5, latency = 4; next cycle an instruction with ra = 5 -> stall_raw = 1 while the producer is in stages 1..3; accepted when the producer reaches stage 4 with fwd_sel_ra = 4; stall_cnt = 3.
- Load dst = 9, latency = 6 issued twice (older in stage 3, younger in stage 1); then read rb = 9 -> matches the stage-1 entry, stalls until stage 6, fwd_sel_rb = 6.
- Producer dst = 12, latency = 2, then 8 non-dependent issues; then read rc = 12 -> no stall, fwd_sel_rc = 0 (register file).
- Branch issue with BR_LAT = 2 and continuous dec_valid -> stall_br = 1 for exactly 2 cycles, then dec_ready = 1; stall_cnt = 2.
- Assert rst = 0 while in BR_PEND with 3 entries valid; release -> a dependent instruction on the old dst issues immediately with fwd_sel = 0 and stall_br = 0.
